// File: rtl/pushbox_pkg.sv
// rtl/pushbox_pkg.sv - shared tile codes, VRAM play-area layout and level ROM geometry
package pushbox_pkg;

   localparam int VRAM_BASE = 120;
   localparam int VRAM_END  = 1200;
   localparam int LEVELS    = 8;
   localparam int CELLS     = VRAM_END - VRAM_BASE;
   localparam int ROM_AW    = 14;

   localparam logic [7:0] TILE_EMPTY         = 8'h00;
   localparam logic [7:0] TILE_WALL          = 8'h01;
   localparam logic [7:0] TILE_FLOOR         = 8'h02;
   localparam logic [7:0] TILE_BOX           = 8'h03;
   localparam logic [7:0] TILE_TARGET        = 8'h04;
   localparam logic [7:0] TILE_PLAYER        = 8'h05;
   localparam logic [7:0] TILE_BOX_ON_TGT    = 8'h06;
   localparam logic [7:0] TILE_PLAYER_ON_TGT = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLR_REQ, ST_CLR_LO, ST_CLR_HI, ST_COPY, ST_FLUSH, ST_FIN
   } load_state_t;

   // level * CELLS as a constant table so no multiplier is built
   function automatic logic [ROM_AW-1:0] level_base(input logic [2:0] lv);
      logic [ROM_AW-1:0] b;
      case (lv)
         3'd0:    b = 14'd0;
         3'd1:    b = 14'd1080;
         3'd2:    b = 14'd2160;
         3'd3:    b = 14'd3240;
         3'd4:    b = 14'd4320;
         3'd5:    b = 14'd5400;
         3'd6:    b = 14'd6480;
         default: b = 14'd7560;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/vram_level_loader_if.sv
// rtl/vram_level_loader_if.sv - level ROM read port and VRAM write port of the loader
interface vram_level_loader_if;
   import pushbox_pkg::*;

   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              vram_we;
   logic [10:0]       vram_addr;
   logic [7:0]        vram_data;

   modport master (output rom_addr, vram_we, vram_addr, vram_data, input rom_data);
   modport slave  (input rom_addr, vram_we, vram_addr, vram_data, output rom_data);

endinterface

// File: rtl/level_scan_stats.sv
// rtl/level_scan_stats.sv - classifies returned tiles and keeps player/box/target statistics
module level_scan_stats
   import pushbox_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        valid,
   input  logic [7:0]  tile,
   input  logic [10:0] addr,
   output logic [10:0] player_addr,
   output logic [7:0]  box_count,
   output logic [7:0]  target_count,
   output logic [1:0]  players
);

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_addr  <= 11'(VRAM_BASE);
         box_count    <= 8'd0;
         target_count <= 8'd0;
         players      <= 2'd0;
      end else if (clr) begin
         player_addr  <= 11'(VRAM_BASE);
         box_count    <= 8'd0;
         target_count <= 8'd0;
         players      <= 2'd0;
      end else if (valid) begin
         // a box already on a target counts only as a target
         if (tile == TILE_BOX)
            box_count <= sat8(box_count);
         if (tile == TILE_TARGET || tile == TILE_BOX_ON_TGT || tile == TILE_PLAYER_ON_TGT)
            target_count <= sat8(target_count);
         if (tile == TILE_PLAYER || tile == TILE_PLAYER_ON_TGT) begin
            player_addr <= addr;
            if (players != 2'd3)
               players <= players + 2'd1;
         end
      end
   end

endmodule

// File: rtl/vram_level_loader.sv
// rtl/vram_level_loader.sv - clears VRAM via vram_clear, then copies one level map from ROM
module vram_level_loader
   import pushbox_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [2:0]          level,
   output logic                clear,
   input  logic                clear_done,
   output logic                clr_own,
   vram_level_loader_if.master mem,
   output logic                busy,
   output logic                done,
   output logic [10:0]         player_addr,
   output logic [7:0]          box_count,
   output logic [7:0]          target_count,
   output logic                err
);

   load_state_t       state, state_nx;
   logic [10:0]       idx;
   logic [ROM_AW-1:0] base;
   logic              pend_valid;
   logic [10:0]       pend_addr;
   logic [1:0]        players;
   logic              accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      clear    = 1'b0;
      clr_own  = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = ST_CLR_REQ;
         end
         ST_CLR_REQ: begin
            clear    = 1'b1;
            clr_own  = 1'b1;
            state_nx = ST_CLR_LO;
         end
         ST_CLR_LO: begin
            clr_own = 1'b1;
            if (!clear_done) state_nx = ST_CLR_HI;
         end
         ST_CLR_HI: begin
            clr_own = 1'b1;
            if (clear_done) state_nx = ST_COPY;
         end
         ST_COPY:  if (idx == 11'(CELLS - 1)) state_nx = ST_FLUSH;
         ST_FLUSH: state_nx = ST_FIN;
         ST_FIN: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign accept = (state == ST_IDLE) && start;

   // pend_* tracks the cell whose ROM byte arrives on the following cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 11'd0;
         base       <= '0;
         pend_valid <= 1'b0;
         pend_addr  <= 11'd0;
         err        <= 1'b0;
      end else begin
         pend_valid <= (state == ST_COPY);
         pend_addr  <= 11'(VRAM_BASE) + idx;
         idx        <= (state == ST_COPY) ? idx + 11'd1 : 11'd0;
         if (accept) begin
            base <= level_base(level);
            err  <= 1'b0;
         end
         if (state == ST_FIN)
            err <= (players != 2'd1);
      end
   end

   assign mem.rom_addr  = (state == ST_COPY) ? base + ROM_AW'(idx) : '0;
   assign mem.vram_we   = pend_valid && (mem.rom_data != TILE_EMPTY);
   assign mem.vram_addr = mem.vram_we ? pend_addr : 11'd0;
   assign mem.vram_data = mem.vram_we ? mem.rom_data : 8'd0;

   level_scan_stats u_stats (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (accept),
      .valid        (pend_valid),
      .tile         (mem.rom_data),
      .addr         (pend_addr),
      .player_addr  (player_addr),
      .box_count    (box_count),
      .target_count (target_count),
      .players      (players)
   );

endmodule

// File: tb/tb_vram_level_loader.sv
// tb/tb_vram_level_loader.sv - scoreboard bench for vram_level_loader with ROM and vram_clear models
module tb_vram_level_loader;
   import pushbox_pkg::*;

   typedef struct { logic [10:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [10:0] pa; logic [7:0] bc; logic [7:0] tc; logic er; } st_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  level = 3'd0;
   logic        clear, clear_done, clr_own, busy, done, err;
   logic [10:0] player_addr;
   logic [7:0]  box_count, target_count;

   vram_level_loader_if vif();

   logic [7:0] rom [0:LEVELS*CELLS-1];
   int nchk = 0, nfail = 0, cyc = 0;
   int clr_cnt = 0, clr_len = 4, clr_pulses = 0;
   int rise_cyc = -1, done_cyc = -1, first_wr_cyc = -1;
   wr_t exp_wr[$];
   st_t exp_st[$];
   wr_t w;
   st_t s;
   logic prev_cd = 1'b1;
   bit   err_due = 1'b0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   vram_level_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .level        (level),
      .clear        (clear),
      .clear_done   (clear_done),
      .clr_own      (clr_own),
      .mem          (vif),
      .busy         (busy),
      .done         (done),
      .player_addr  (player_addr),
      .box_count    (box_count),
      .target_count (target_count),
      .err          (err)
   );

   // synchronous level ROM and a vram_clear stand-in: done drops 2 cycles after clear
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (vif.rom_addr < 14'(LEVELS*CELLS)) vif.rom_data <= rom[vif.rom_addr];
      else                                   vif.rom_data <= 8'h00;
      if (clear)            clr_cnt <= 1;
      else if (clr_cnt > 0) clr_cnt <= clr_cnt + 1;
   end
   assign clear_done = !(clr_cnt >= 2 && clr_cnt < 2 + clr_len);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   always @(negedge clk) begin
      if (err_due) begin
         check("err_after_done", err, exp_err);
         err_due = 1'b0;
      end
      if (clear) clr_pulses++;
      if (clear_done && !prev_cd) rise_cyc = cyc;
      prev_cd = clear_done;
      if (clr_own) check("we_during_clear", vif.vram_we, 0);
      if (vif.vram_we) begin
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         if (exp_wr.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", vif.vram_addr, vif.vram_data);
         end else begin
            w = exp_wr.pop_front();
            check("vram_addr", vif.vram_addr, w.addr);
            check("vram_data", vif.vram_data, w.data);
         end
      end
      if (done) begin
         done_cyc = cyc;
         if (exp_st.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_done: got done=1, expected none");
         end else begin
            s = exp_st.pop_front();
            check("player_addr", player_addr, s.pa);
            check("box_count", box_count, s.bc);
            check("target_count", target_count, s.tc);
            check("busy_at_done", busy, 1);
            exp_err = s.er;
            err_due = 1'b1;
         end
      end
   end

   task automatic push_writes(input int lv, input int n);
      for (int i = 0; i < n; i++)
         if (rom[lv*CELLS+i] != TILE_EMPTY)
            exp_wr.push_back('{11'(VRAM_BASE + i), rom[lv*CELLS+i]});
   endtask

   task automatic push_stats(input logic [10:0] pa, input logic [7:0] bc, input logic [7:0] tc, input logic er);
      exp_st.push_back('{pa, bc, tc, er});
   endtask

   task automatic start_load(input logic [2:0] lv, input int clen);
      clr_len = clen;
      @(negedge clk);
      level = lv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_finished"}, busy, 0);
      check({name, "_writes_left"}, exp_wr.size(), 0);
      @(negedge clk);
      check({name, "_results_left"}, exp_st.size(), 0);
   endtask

   task automatic wait_rom_addr(input logic [13:0] a, input int budget);
      int n;
      n = 0;
      while (vif.rom_addr != a && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("copy_position", vif.rom_addr, a);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_clear"}, clear, 0);
      check({name, "_clr_own"}, clr_own, 0);
      check({name, "_vram_we"}, vif.vram_we, 0);
      check({name, "_vram_addr"}, vif.vram_addr, 0);
      check({name, "_vram_data"}, vif.vram_data, 0);
      check({name, "_rom_addr"}, vif.rom_addr, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_done"}, done, 0);
      check({name, "_player_addr"}, player_addr, 120);
      check({name, "_box_count"}, box_count, 0);
      check({name, "_target_count"}, target_count, 0);
      check({name, "_err"}, err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < LEVELS*CELLS; i++) rom[i] = TILE_EMPTY;
      for (int i = 0; i < CELLS; i++) begin
         rom[0*CELLS+i] = (i == 0) ? TILE_PLAYER : TILE_WALL;
         rom[2*CELLS+i] = TILE_FLOOR;
         rom[5*CELLS+i] = TILE_BOX;
      end
      rom[2*CELLS+0]    = TILE_BOX;
      rom[2*CELLS+5]    = TILE_BOX_ON_TGT;
      rom[2*CELLS+6]    = TILE_TARGET;
      rom[2*CELLS+1079] = TILE_PLAYER;
      rom[4*CELLS+10]   = TILE_PLAYER;
      rom[4*CELLS+20]   = TILE_PLAYER;
      rom[6*CELLS+0]    = TILE_PLAYER_ON_TGT;
      rom[6*CELLS+1079] = TILE_TARGET;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // level 0 with a full-length clear
      push_writes(0, CELLS);
      push_stats(11'd120, 8'd0, 8'd0, 1'b0);
      start_load(3'd0, 1080);
      check("clear_pulse_after_start", clear, 1);
      wait_idle("lvl0", 5000);
      check("lvl0_clear_pulses", clr_pulses, 1);
      check("lvl0_done_latency", done_cyc - rise_cyc, 1082);
      check("lvl0_first_write_delay", first_wr_cyc - rise_cyc, 2);

      push_writes(2, CELLS);
      push_stats(11'd1199, 8'd1, 8'd2, 1'b0);
      start_load(3'd2, 5);
      wait_idle("lvl2", 3000);

      push_stats(11'd120, 8'd0, 8'd0, 1'b1);
      start_load(3'd3, 5);
      wait_idle("lvl3_empty", 3000);

      push_writes(4, CELLS);
      push_stats(11'd140, 8'd0, 8'd0, 1'b1);
      start_load(3'd4, 5);
      wait_idle("lvl4_two_players", 3000);

      // all boxes saturate the counter; starts during COPY and FIN are ignored
      push_writes(5, CELLS);
      push_stats(11'd120, 8'd255, 8'd0, 1'b1);
      start_load(3'd5, 3);
      wait_rom_addr(14'(5*CELLS + 100), 200);
      level = 3'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("lvl5_done_seen", done, 1);
      push_writes(6, CELLS);
      push_stats(11'd120, 8'd0, 8'd2, 1'b0);
      level = 3'd6;
      start = 1'b1;
      @(negedge clk);
      check("start_in_fin_ignored", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("restart_accepted", clear, 1);
      check("err_cleared_on_start", err, 0);
      wait_idle("lvl6", 3000);
      check("total_clear_pulses", clr_pulses, 6);

      // reset in the middle of the copy
      push_writes(0, 500);
      start_load(3'd0, 4);
      wait_rom_addr(14'd500, 1000);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      check("mid_reset_writes_left", exp_wr.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_after_reset", busy, 0);
      check("final_clear_pulses", clr_pulses, 7);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
